// File: rtl/alu_8_if.sv
// Operand/result bundle for the 8-bit execute-stage ALU.
// The master side issues operations; the slave side (the ALU) returns registered results.
interface alu_8_if;
    logic       in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] op;
    logic [7:0] Y;
    logic       Z;
    logic       C;
    logic       V;
    logic       out_valid;

    modport master (
        output in_valid, A, B, op,
        input  Y, Z, C, V, out_valid
    );

    modport slave (
        input  in_valid, A, B, op,
        output Y, Z, C, V, out_valid
    );
endinterface

// File: rtl/alu_8.sv
// 8-bit registered ALU: eight operations with zero/carry/overflow flags and one-cycle latency.
// Results and flags hold between issued operations; out_valid pulses once per captured operation.
module alu_8 (
    input  logic    clk,
    input  logic    rst_n,
    alu_8_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_SHR  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic [8:0] ext9;
    logic [7:0] res;
    logic       c_res;
    logic       v_res;

    logic [7:0] y_d, y_q;
    logic       z_d, z_q;
    logic       c_d, c_q;
    logic       v_d, v_q;
    logic       out_valid_d, out_valid_q;

    // Combinational result and flags for the operation currently presented.
    always_comb begin
        ext9  = '0;
        res   = '0;
        c_res = 1'b0;
        v_res = 1'b0;
        case (op_e'(bus.op))
            OP_ADD: begin
                ext9  = {1'b0, bus.A} + {1'b0, bus.B};
                res   = ext9[7:0];
                c_res = ext9[8];
                v_res = (bus.A[7] == bus.B[7]) && (res[7] != bus.A[7]);
            end
            OP_SUB: begin
                // Bit 8 of the 9-bit difference is the borrow (A < B unsigned).
                ext9  = {1'b0, bus.A} - {1'b0, bus.B};
                res   = ext9[7:0];
                c_res = ext9[8];
                v_res = (bus.A[7] != bus.B[7]) && (res[7] != bus.A[7]);
            end
            OP_AND:  res = bus.A & bus.B;
            OP_OR:   res = bus.A | bus.B;
            OP_XOR:  res = bus.A ^ bus.B;
            OP_SHL: begin
                res   = {bus.A[6:0], 1'b0};
                c_res = bus.A[7];
            end
            OP_SHR: begin
                res   = {1'b0, bus.A[7:1]};
                c_res = bus.A[0];
            end
            OP_PASS: res = bus.A;
            default: res = '0;
        endcase
    end

    // Next-state: capture on in_valid, otherwise hold result/flags and drop out_valid.
    always_comb begin
        y_d         = y_q;
        z_d         = z_q;
        c_d         = c_q;
        v_d         = v_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            y_d = res;
            z_d = (res == 8'h00);
            c_d = c_res;
            v_d = v_res;
        end
    end

    // Output registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q         <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.Y         = y_q;
    assign bus.Z         = z_q;
    assign bus.C         = c_q;
    assign bus.V         = v_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_8.sv
// Self-checking bench for alu_8: every driven cycle pushes the expected post-edge state
// into a scoreboard queue, and a negedge monitor pops and compares it.
module tb_alu_8;

    typedef struct {
        logic       vld;
        logic [7:0] y;
        logic       z;
        logic       c;
        logic       v;
    } exp_t;

    logic clk;
    logic rst_n;
    alu_8_if bus ();

    alu_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    // Reference-model held state (what the outputs should show when nothing is captured).
    logic [7:0] m_y;
    logic       m_z, m_c, m_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent arithmetic model using signed integer ranges for overflow.
    task automatic model_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            output logic [7:0] y, output logic c, output logic v);
        int ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (op)
            3'd0: begin
                r  = ua + ub;
                c  = (r > 255);
                sr = sa + sb;
                v  = (sr > 127) || (sr < -128);
            end
            3'd1: begin
                r  = ua - ub;
                c  = (ua < ub);
                sr = sa - sb;
                v  = (sr > 127) || (sr < -128);
            end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin
                r = ua * 2;
                c = (ua >= 128);
            end
            3'd6: begin
                r = ua / 2;
                c = (ua % 2) == 1;
            end
            default: r = ua;
        endcase
        y = 8'(r & 255);
    endtask

    // Drive one cycle of inputs, push what the outputs must be after the next edge, advance.
    task automatic drive(input logic rst, input logic vld, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
        exp_t       e;
        logic [7:0] y;
        logic       c, v;
        rst_n        = rst;
        bus.in_valid = vld;
        bus.A        = a;
        bus.B        = b;
        bus.op       = op;
        if (!rst) begin
            m_y = 8'h00; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
            e.vld = 1'b0;
        end else if (vld) begin
            model_op(a, b, op, y, c, v);
            m_y = y; m_z = (y == 8'h00); m_c = c; m_v = v;
            e.vld = 1'b1;
        end else begin
            e.vld = 1'b0;
        end
        e.y = m_y; e.z = m_z; e.c = m_c; e.v = m_v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Compare DUT outputs against the scoreboard away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid", 32'(bus.out_valid), 32'(e.vld));
            check("Y", 32'(bus.Y), 32'(e.y));
            check("Z", 32'(bus.Z), 32'(e.z));
            check("C", 32'(bus.C), 32'(e.c));
            check("V", 32'(bus.V), 32'(e.v));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_y = 8'h00; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;

        // Reset held two edges with a live operation presented, then released.
        drive(1'b0, 1'b1, 8'hFF, 8'h01, 3'b000);
        drive(1'b0, 1'b1, 8'hFF, 8'h01, 3'b000);
        drive(1'b1, 1'b1, 8'hFF, 8'h01, 3'b000);

        // ADD
        drive(1'b1, 1'b1, 8'h00, 8'h00, 3'b000);
        drive(1'b1, 1'b1, 8'h05, 8'h03, 3'b000);
        drive(1'b1, 1'b1, 8'h7F, 8'h01, 3'b000);
        // SUB
        drive(1'b1, 1'b1, 8'h05, 8'h03, 3'b001);
        drive(1'b1, 1'b1, 8'h00, 8'h01, 3'b001);
        drive(1'b1, 1'b1, 8'h80, 8'h01, 3'b001);
        // Logic and pass
        drive(1'b1, 1'b1, 8'hF0, 8'h0F, 3'b010);
        drive(1'b1, 1'b1, 8'hF0, 8'h0F, 3'b011);
        drive(1'b1, 1'b1, 8'hFF, 8'h0F, 3'b100);
        drive(1'b1, 1'b1, 8'hAA, 8'h55, 3'b111);
        // Shifts (B deliberately nonzero: it must be ignored)
        drive(1'b1, 1'b1, 8'h80, 8'hFF, 3'b101);
        drive(1'b1, 1'b1, 8'h41, 8'hFF, 3'b101);
        drive(1'b1, 1'b1, 8'h01, 8'hFF, 3'b110);
        drive(1'b1, 1'b1, 8'h80, 8'hFF, 3'b110);

        // Three back-to-back ops, then idle with changing inputs: outputs must hold.
        drive(1'b1, 1'b1, 8'h12, 8'h34, 3'b000);
        drive(1'b1, 1'b1, 8'h90, 8'h20, 3'b001);
        drive(1'b1, 1'b1, 8'hC3, 8'h3C, 3'b100);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
        drive(1'b1, 1'b0, 8'hFF, 8'hFF, 3'b001);
        drive(1'b1, 1'b0, 8'h80, 8'h01, 3'b101);

        // Reset mid-stream discards the in-flight op; first op after release is captured.
        drive(1'b1, 1'b1, 8'h7F, 8'h7F, 3'b000);
        drive(1'b0, 1'b1, 8'h01, 8'h01, 3'b000);
        drive(1'b1, 1'b1, 8'h03, 8'h05, 3'b001);

        // Randomised traffic with sparse idles.
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)));
        end
        drive(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
